hazard_control_unit: RTL and testbench

Pipeline sequencer for the 5-stage RISC-V core, paired with the forwarding unit. Detects load-use hazards, flushes on taken branches, and freezes the front of the pipeline while a fixed-latency multi-cycle (mul/div) instruction occupies EX. Drives the PC and IF/ID/ID/EX write-enables and bubble/flush controls.

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/hazard_control_unit_if.sv | 29 ++
 rtl/hazard_perf_ctr.sv | 21 ++
 rtl/hazard_control_unit.sv | 106 ++++++++++
 tb/tb_hazard_control_unit.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states and control constants.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hzd_state_t;

  localparam logic [4:0] NOP_RD   = 5'd0;
  localparam int         MD_CNT_W = 5;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard control unit (slave).
interface hazard_control_unit_if;

  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic [4:0] idex_rd;
  logic       idex_mem_read;
  logic       ex_muldiv;
  logic       branch_taken;

  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_flush;
  logic       exmem_bubble;
  logic       md_done;

  modport master (
    output ifid_rs1, ifid_rs2, idex_rd, idex_mem_read, ex_muldiv, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, md_done
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, idex_rd, idex_mem_read, ex_muldiv, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, md_done
  );

endinterface

// File: rtl/hazard_perf_ctr.sv
// 32-bit wrapping event counter; one increment per clock while inc_i is high.
module hazard_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else if (inc_i) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes and mul/div EX holds.
// Optional macro HAZARD_PERF_EN adds stall_cycles/flush_events performance counters.
module hazard_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_control_unit_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events
`endif
);

  // The entry cycle is itself the first hold cycle, so the counter starts two short.
  localparam logic [MD_CNT_W-1:0] MD_LOAD =
    (MD_LATENCY > 1) ? MD_CNT_W'(MD_LATENCY - 2) : '0;

  hzd_state_t          state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                load_use;

  assign load_use = hz.idex_mem_read && (hz.idex_rd != NOP_RD) &&
                    ((hz.idex_rd == hz.ifid_rs1) || (hz.idex_rd == hz.ifid_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    md_cnt_d        = md_cnt_q;
    hz.pc_write     = 1'b1;
    hz.ifid_write   = 1'b1;
    hz.ifid_flush   = 1'b0;
    hz.idex_write   = 1'b1;
    hz.idex_flush   = 1'b0;
    hz.exmem_bubble = 1'b0;
    hz.md_done      = 1'b0;

    case (state_q)
      RUN: begin
        if (hz.branch_taken) begin
          hz.ifid_flush = 1'b1;
          hz.idex_flush = 1'b1;
        end else if (hz.ex_muldiv) begin
          if (MD_LATENCY > 1) begin
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.idex_write   = 1'b0;
            hz.exmem_bubble = 1'b1;
            md_cnt_d        = MD_LOAD;
            state_d         = MD_BUSY;
          end else begin
            hz.md_done = 1'b1;
          end
        end else if (load_use) begin
          hz.pc_write   = 1'b0;
          hz.ifid_write = 1'b0;
          hz.idex_flush = 1'b1;
        end
      end

      MD_BUSY: begin
        if (md_cnt_q != '0) begin
          hz.pc_write     = 1'b0;
          hz.ifid_write   = 1'b0;
          hz.idex_write   = 1'b0;
          hz.exmem_bubble = 1'b1;
          md_cnt_d        = md_cnt_q - MD_CNT_W'(1);
        end else begin
          hz.md_done = 1'b1;
          state_d    = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_ctr u_stall_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (!hz.pc_write),
    .count_o (stall_cycles)
  );

  hazard_perf_ctr u_flush_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (hz.ifid_flush),
    .count_o (flush_events)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: one DUT with MD_LATENCY=4, one with MD_LATENCY=1.
// Output vectors pack {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, md_done}.
module tb_hazard_control_unit;

  localparam logic [6:0] NORM    = 7'b1101000;
  localparam logic [6:0] HOLD    = 7'b0000010;
  localparam logic [6:0] DONE    = 7'b1101001;
  localparam logic [6:0] LDUSE   = 7'b0001100;
  localparam logic [6:0] BRANCH  = 7'b1111100;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  hazard_control_unit_if ifA ();
  hazard_control_unit_if ifB ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stallA, flushA, stallB, flushB;
`endif

  hazard_control_unit #(.MD_LATENCY(4)) dutA (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz           (ifA.slave)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stallA),
    .flush_events (flushA)
`endif
  );

  hazard_control_unit #(.MD_LATENCY(1)) dutB (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz           (ifB.slave)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stallB),
    .flush_events (flushB)
`endif
  );

  assign ifB.ifid_rs1      = ifA.ifid_rs1;
  assign ifB.ifid_rs2      = ifA.ifid_rs2;
  assign ifB.idex_rd       = ifA.idex_rd;
  assign ifB.idex_mem_read = ifA.idex_mem_read;
  assign ifB.ex_muldiv     = ifA.ex_muldiv;
  assign ifB.branch_taken  = ifA.branch_taken;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A taken branch and a mul/div in EX together is an illegal pipeline state.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(ifA.branch_taken && ifA.ex_muldiv))
      else begin
        miscompares++;
        $error("[TB] FAIL illegal_branch_muldiv observed=1 expected=0");
      end
    end
  end

  function automatic logic [6:0] packA();
    return {ifA.pc_write, ifA.ifid_write, ifA.ifid_flush, ifA.idex_write,
            ifA.idex_flush, ifA.exmem_bubble, ifA.md_done};
  endfunction

  function automatic logic [6:0] packB();
    return {ifB.pc_write, ifB.ifid_write, ifB.ifid_flush, ifB.idex_write,
            ifB.idex_flush, ifB.exmem_bubble, ifB.md_done};
  endfunction

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic memRead,
                               input logic mulDiv, input logic branch);
    ifA.ifid_rs1      = rs1;
    ifA.ifid_rs2      = rs2;
    ifA.idex_rd       = rd;
    ifA.idex_mem_read = memRead;
    ifA.ex_muldiv     = mulDiv;
    ifA.branch_taken  = branch;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock step: drive on the falling edge, check once combinational outputs settle.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic memRead, input logic mulDiv, input logic branch,
                      input logic [6:0] expA, input string tag);
    @(negedge clk);
    applyStimulus(rs1, rs2, rd, memRead, mulDiv, branch);
    #1;
    checkOutput(tag, 32'(packA()), 32'(expA));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_A", 32'(packA()), 32'(NORM));
    checkOutput("reset_B", 32'(packB()), 32'(NORM));

    @(negedge clk);
    rst_n = 1'b1;

    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,   "idle");
    step(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, LDUSE,  "loaduse_rs2");
    step(5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, NORM,   "loaduse_one_cycle");
    step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, NORM,   "loaduse_rd_x0");
    step(5'd3, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, NORM,   "loaduse_rd0_rs2");
    step(5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, LDUSE,  "loaduse_rs1");
    step(5'd7, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0, NORM,   "load_no_match");
    step(5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, BRANCH, "branch_over_loaduse");

    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "md_t0");
    checkOutput("md_lat1_done", 32'(packB()), 32'(DONE));
    step(5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, HOLD,   "md_t1_ignore_loaduse");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "md_t2");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, DONE,   "md_t3_done");
    step(5'd4, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, LDUSE,  "run_after_md");

    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "b2b_first_t0");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "b2b_first_t1");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "b2b_first_t2");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, DONE,   "b2b_first_done");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "b2b_second_no_gap");
    checkOutput("b2b_lat1_done", 32'(packB()), 32'(DONE));
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "b2b_second_t1");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "b2b_second_t2");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, DONE,   "b2b_second_done");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,   "b2b_after");

    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "abort_t0");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "abort_t1");
    #1;
    rst_n = 1'b0;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("abort_async_reset", 32'(packA()), 32'(NORM));
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,   "abort_in_reset");
    rst_n = 1'b1;
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,   "abort_no_done_1");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,   "abort_no_done_2");

    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "post_reset_md_t0");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "post_reset_md_t1");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLD,   "post_reset_md_t2");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, DONE,   "post_reset_md_done");
    step(5'd8, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, LDUSE,  "post_reset_loaduse");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,   "post_reset_idle");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, BRANCH, "post_reset_branch");
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,   "post_reset_final");

`ifdef HAZARD_PERF_EN
    checkOutput("perf_stall_cycles_A", stallA, 32'd4);
    checkOutput("perf_flush_events_A", flushA, 32'd1);
    checkOutput("perf_stall_cycles_B", stallB, 32'd1);
    checkOutput("perf_flush_events_B", flushB, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
